// File: rtl/gshare_predictor.sv
// rtl/gshare_predictor.sv - gshare direction predictor with tagged BTB; optional stats via GSHARE_PREDICTOR_STATS_EN
module gshare_predictor #(
    parameter int N      = 128,
    parameter int IDX    = 7,
    parameter int CTR_W  = 2,
    parameter int HIST_W = 4,
    parameter int TAG_W  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [15:0]       pc_fetch,
    output logic              predict_taken,
    output logic [15:0]       predict_target,
    output logic              btb_hit,
    output logic [HIST_W-1:0] ghr,
    input  logic              update_en,
    input  logic [15:0]       pc_resolve,
    input  logic              taken,
    input  logic [15:0]       target,
    input  logic              update_mispredict,
    input  logic              ghr_restore_en,
    input  logic [HIST_W-1:0] ghr_restore_val
`ifdef GSHARE_PREDICTOR_STATS_EN
    ,
    output logic [31:0]       stat_updates,
    output logic [31:0]       stat_mispredicts
`endif
);

    localparam logic [CTR_W-1:0] CTR_MAX  = '1;
    localparam logic [CTR_W-1:0] CTR_INIT = CTR_W'((1 << (CTR_W - 1)) - 1);

    logic [CTR_W-1:0]  r_bht        [N];
    logic [N-1:0]      r_btb_valid;
    logic [TAG_W-1:0]  r_btb_tag    [N];
    logic [15:0]       r_btb_target [N];
    logic [HIST_W-1:0] r_ghr;

    logic [IDX-1:0]    w_f_tidx;
    logic [IDX-1:0]    w_f_bidx;
    logic [TAG_W-1:0]  w_f_tag;
    logic [IDX-1:0]    w_r_tidx;
    logic [IDX-1:0]    w_r_bidx;
    logic [TAG_W-1:0]  w_r_tag;
    logic [CTR_W-1:0]  w_ctr_cur;
    logic [CTR_W-1:0]  w_ctr_next;
    logic [HIST_W-1:0] w_ghr_next;
    logic              w_unused;

    // Bits of the PCs outside index/tag fields carry no information here.
    assign w_unused = ^{pc_fetch, pc_resolve, update_mispredict};

    assign w_f_tidx = pc_fetch[IDX:1];
    assign w_f_bidx = w_f_tidx ^ IDX'(r_ghr);
    assign w_f_tag  = pc_fetch[IDX+TAG_W:IDX+1];

    assign w_r_tidx  = pc_resolve[IDX:1];
    assign w_r_bidx  = w_r_tidx ^ IDX'(r_ghr);
    assign w_r_tag   = pc_resolve[IDX+TAG_W:IDX+1];
    assign w_ctr_cur = r_bht[w_r_bidx];

    // Lookup reads pre-edge table contents; there is deliberately no bypass.
    always_comb begin
        btb_hit        = r_btb_valid[w_f_tidx] && (r_btb_tag[w_f_tidx] == w_f_tag);
        predict_taken  = r_bht[w_f_bidx][CTR_W-1] && btb_hit;
        predict_target = predict_taken ? r_btb_target[w_f_tidx] : 16'h0000;
    end

    assign ghr = r_ghr;

    // Saturating counter step for the resolved branch.
    always_comb begin
        w_ctr_next = w_ctr_cur;
        if (taken && (w_ctr_cur != CTR_MAX)) begin
            w_ctr_next = w_ctr_cur + CTR_W'(1);
        end else if (!taken && (w_ctr_cur != '0)) begin
            w_ctr_next = w_ctr_cur - CTR_W'(1);
        end
    end

    // Next history: shift in the outcome, then let a flush restore override it.
    always_comb begin
        w_ghr_next = r_ghr;
        if (update_en) begin
            w_ghr_next = HIST_W'({r_ghr, taken});
        end
        if (ghr_restore_en) begin
            w_ghr_next = ghr_restore_val;
        end
    end

    // BHT and BTB storage; tables are indexed with the pre-edge history.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_btb_valid <= '0;
            for (int i = 0; i < N; i++) begin
                r_bht[i]        <= CTR_INIT;
                r_btb_tag[i]    <= '0;
                r_btb_target[i] <= '0;
            end
        end else if (update_en) begin
            r_bht[w_r_bidx] <= w_ctr_next;
            if (taken) begin
                r_btb_valid[w_r_tidx]  <= 1'b1;
                r_btb_tag[w_r_tidx]    <= w_r_tag;
                r_btb_target[w_r_tidx] <= target;
            end
        end
    end

    // Global history register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ghr <= '0;
        end else begin
            r_ghr <= w_ghr_next;
        end
    end

`ifdef GSHARE_PREDICTOR_STATS_EN
    logic [31:0] r_stat_updates;
    logic [31:0] r_stat_mispredicts;

    // Saturating update and mispredict counters.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_stat_updates     <= '0;
            r_stat_mispredicts <= '0;
        end else if (update_en) begin
            if (r_stat_updates != 32'hFFFF_FFFF) begin
                r_stat_updates <= r_stat_updates + 32'd1;
            end
            if (update_mispredict && (r_stat_mispredicts != 32'hFFFF_FFFF)) begin
                r_stat_mispredicts <= r_stat_mispredicts + 32'd1;
            end
        end
    end

    assign stat_updates     = r_stat_updates;
    assign stat_mispredicts = r_stat_mispredicts;
`endif

endmodule

// File: tb/tb_gshare_predictor.sv
// tb/tb_gshare_predictor.sv - self-checking bench for gshare_predictor
module tb_gshare_predictor;

    localparam int NE    = 128;
    localparam int CMAX  = 3;
    localparam int CINIT = 1;

    logic        clk;
    logic        rst_n;
    logic [15:0] pc_fetch;
    logic        predict_taken;
    logic [15:0] predict_target;
    logic        btb_hit;
    logic [3:0]  ghr;
    logic        update_en;
    logic [15:0] pc_resolve;
    logic        taken;
    logic [15:0] target;
    logic        update_mispredict;
    logic        ghr_restore_en;
    logic [3:0]  ghr_restore_val;
`ifdef GSHARE_PREDICTOR_STATS_EN
    logic [31:0] stat_updates;
    logic [31:0] stat_mispredicts;
`endif

    gshare_predictor dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .pc_fetch          (pc_fetch),
        .predict_taken     (predict_taken),
        .predict_target    (predict_target),
        .btb_hit           (btb_hit),
        .ghr               (ghr),
        .update_en         (update_en),
        .pc_resolve        (pc_resolve),
        .taken             (taken),
        .target            (target),
        .update_mispredict (update_mispredict),
        .ghr_restore_en    (ghr_restore_en),
        .ghr_restore_val   (ghr_restore_val)
`ifdef GSHARE_PREDICTOR_STATS_EN
        ,
        .stat_updates      (stat_updates),
        .stat_mispredicts  (stat_mispredicts)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit chk_en = 0;

    // Reference model state
    int          m_bht [NE];
    bit          m_v   [NE];
    int          m_tag [NE];
    int          m_tgt [NE];
    int          m_ghr;
    logic [31:0] m_upd;
    logic [31:0] m_mis;

    function automatic int f_tidx(input int pc);
        return (pc / 2) % NE;
    endfunction

    function automatic int f_tag(input int pc);
        return (pc / 256) % 16;
    endfunction

    function automatic int f_bidx(input int pc, input int g);
        return f_tidx(pc) ^ g;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: apply the resolved branch at each rising edge.
    always @(posedge clk) begin : model
        int b;
        int t;
        int gn;
        if (!rst_n) begin
            for (int i = 0; i < NE; i++) begin
                m_bht[i] = CINIT;
                m_v[i]   = 0;
                m_tag[i] = 0;
                m_tgt[i] = 0;
            end
            m_ghr = 0;
            m_upd = 0;
            m_mis = 0;
        end else begin
            gn = m_ghr;
            if (update_en) begin
                b = f_bidx(int'(pc_resolve), m_ghr);
                if (taken) m_bht[b] = (m_bht[b] + 1 > CMAX) ? CMAX : m_bht[b] + 1;
                else       m_bht[b] = (m_bht[b] - 1 < 0) ? 0 : m_bht[b] - 1;
                if (taken) begin
                    t = f_tidx(int'(pc_resolve));
                    m_v[t]   = 1;
                    m_tag[t] = f_tag(int'(pc_resolve));
                    m_tgt[t] = int'(target);
                end
                gn = (m_ghr * 2 + int'(taken)) % 16;
                if (m_upd != 32'hFFFF_FFFF) m_upd = m_upd + 1;
                if (update_mispredict && m_mis != 32'hFFFF_FFFF) m_mis = m_mis + 1;
            end
            if (ghr_restore_en) gn = int'(ghr_restore_val);
            m_ghr = gn;
        end
    end

    // Compare DUT outputs against the model away from the rising edge.
    always @(negedge clk) begin : compare
        int  t;
        bit  e_hit;
        bit  e_tk;
        int  e_tgt;
        if (chk_en) begin
            t     = f_tidx(int'(pc_fetch));
            e_hit = m_v[t] && (m_tag[t] == f_tag(int'(pc_fetch)));
            e_tk  = e_hit && (m_bht[f_bidx(int'(pc_fetch), m_ghr)] > CMAX / 2);
            e_tgt = e_tk ? m_tgt[t] : 0;
            chk("cmp_btb_hit", 32'(btb_hit), 32'(e_hit));
            chk("cmp_taken", 32'(predict_taken), 32'(e_tk));
            chk("cmp_target", 32'(predict_target), 32'(e_tgt));
            chk("cmp_ghr", 32'(ghr), 32'(m_ghr));
`ifdef GSHARE_PREDICTOR_STATS_EN
            chk("cmp_stat_upd", stat_updates, m_upd);
            chk("cmp_stat_mis", stat_mispredicts, m_mis);
`endif
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic idle();
        update_en         = 1'b0;
        taken             = 1'b0;
        update_mispredict = 1'b0;
        ghr_restore_en    = 1'b0;
        ghr_restore_val   = 4'h0;
    endtask

    task automatic upd(input logic [15:0] pc, input logic tk, input logic [15:0] tg,
                       input logic ren, input logic [3:0] rv, input logic mp);
        tick();
        update_en         = 1'b1;
        pc_resolve        = pc;
        taken             = tk;
        target            = tg;
        ghr_restore_en    = ren;
        ghr_restore_val   = rv;
        update_mispredict = mp;
    endtask

    task automatic look(input logic [15:0] pc);
        tick();
        idle();
        pc_fetch = pc;
        #1;
    endtask

    task automatic do_reset(input int n);
        tick();
        idle();
        rst_n = 1'b0;
        repeat (n) @(posedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n      = 1'b0;
        pc_fetch   = 16'h0;
        pc_resolve = 16'h0;
        target     = 16'h0;
        idle();

        do_reset(2);
        chk_en = 1;

        // Reset sweep
        for (int p = 0; p <= 16'h00FE; p += 2) begin
            tick();
            pc_fetch = 16'(p);
            #1;
            chk("rst_sweep", 32'({predict_taken, btb_hit, predict_target, ghr}), 32'h0);
        end

        // Saturation up
        repeat (3) upd(16'h0010, 1'b1, 16'h0040, 1'b1, 4'h0, 1'b0);
        look(16'h0010);
        chk("sat_up_taken", 32'(predict_taken), 32'h1);
        chk("sat_up_target", 32'(predict_target), 32'h0040);
        chk("sat_up_hit", 32'(btb_hit), 32'h1);
        // Saturation down; not-taken target must not reach the BTB
        repeat (3) upd(16'h0010, 1'b0, 16'h1234, 1'b1, 4'h0, 1'b0);
        look(16'h0010);
        chk("sat_dn_taken", 32'(predict_taken), 32'h0);
        chk("sat_dn_hit", 32'(btb_hit), 32'h1);
        upd(16'h0010, 1'b1, 16'h0040, 1'b1, 4'h0, 1'b0);
        look(16'h0010);
        chk("sat_01_taken", 32'(predict_taken), 32'h0);
        upd(16'h0010, 1'b1, 16'h0040, 1'b1, 4'h0, 1'b0);
        look(16'h0010);
        chk("sat_10_taken", 32'(predict_taken), 32'h1);
        chk("sat_10_target", 32'(predict_target), 32'h0040);

        // Tag miss on the same tidx
        look(16'h0110);
        chk("tagmiss_hit", 32'(btb_hit), 32'h0);
        chk("tagmiss_taken", 32'(predict_taken), 32'h0);
        chk("tagmiss_target", 32'(predict_target), 32'h0);

        // Gshare indexing
        do_reset(2);
        upd(16'h0010, 1'b1, 16'h0040, 1'b0, 4'h0, 1'b0);
        look(16'h0010);
        chk("gs_ghr", 32'(ghr), 32'h1);
        chk("gs_hit", 32'(btb_hit), 32'h1);
        chk("gs_taken", 32'(predict_taken), 32'h0);

        // Bring bidx 0x08 to 01 with ghr 0
        upd(16'h0010, 1'b0, 16'h0, 1'b1, 4'h0, 1'b0);
        upd(16'h0010, 1'b0, 16'h0, 1'b1, 4'h0, 1'b0);
        look(16'h0010);
        chk("col_setup_taken", 32'(predict_taken), 32'h0);

        // Same-cycle lookup and update on the same entry
        tick();
        pc_fetch        = 16'h0010;
        update_en       = 1'b1;
        pc_resolve      = 16'h0010;
        taken           = 1'b1;
        target          = 16'h0040;
        ghr_restore_en  = 1'b1;
        ghr_restore_val = 4'h0;
        #1;
        chk("col_pre_taken", 32'(predict_taken), 32'h0);
        chk("col_pre_hit", 32'(btb_hit), 32'h1);
        tick();
        idle();
        #1;
        chk("col_post_taken", 32'(predict_taken), 32'h1);
        chk("col_post_target", 32'(predict_target), 32'h0040);
        chk("col_restore_ghr", 32'(ghr), 32'h0);

        // Restore to nonzero; table write must use pre-edge history
        upd(16'h0010, 1'b1, 16'h0040, 1'b1, 4'hA, 1'b0);
        look(16'h0010);
        chk("rst_a_ghr", 32'(ghr), 32'hA);
        chk("rst_a_taken", 32'(predict_taken), 32'h0);
        tick();
        ghr_restore_en  = 1'b1;
        ghr_restore_val = 4'h0;
        look(16'h0010);
        chk("rst_0_ghr", 32'(ghr), 32'h0);
        chk("rst_0_taken", 32'(predict_taken), 32'h1);

        // Directed mixed traffic, checked by the compare process
        for (int i = 0; i < 40; i++) begin
            upd(16'((i * 38) % 1024), (i % 3) != 0, 16'(i * 16'h0111),
                (i % 7) == 0, 4'(i), (i % 2) == 1);
            pc_fetch = 16'(((i + 1) * 38) % 1024);
        end
        look(16'h0026);

        // Stats and mid-run reset
        do_reset(2);
        for (int i = 0; i < 5; i++) begin
            upd(16'h0010, 1'b1, 16'h0040, 1'b1, 4'h0, i < 2);
        end
        look(16'h0010);
        chk("pre_rst_taken", 32'(predict_taken), 32'h1);
`ifdef GSHARE_PREDICTOR_STATS_EN
        chk("stat_updates_5", stat_updates, 32'd5);
        chk("stat_mispredicts_2", stat_mispredicts, 32'd2);
`endif
        tick();
        rst_n           = 1'b0;
        update_en       = 1'b1;
        pc_resolve      = 16'h0010;
        taken           = 1'b1;
        target          = 16'h0040;
        ghr_restore_en  = 1'b1;
        ghr_restore_val = 4'h5;
        tick();
        rst_n = 1'b1;
        idle();
        pc_fetch = 16'h0010;
        #1;
        chk("mid_rst_taken", 32'(predict_taken), 32'h0);
        chk("mid_rst_hit", 32'(btb_hit), 32'h0);
        chk("mid_rst_target", 32'(predict_target), 32'h0);
        chk("mid_rst_ghr", 32'(ghr), 32'h0);
`ifdef GSHARE_PREDICTOR_STATS_EN
        chk("mid_rst_stat_upd", stat_updates, 32'd0);
        chk("mid_rst_stat_mis", stat_mispredicts, 32'd0);
`endif
        tick();
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/gshare_predictor.md
Name: gshare_predictor

Overview:
- Parametrised successor to the fetch-stage bimodal predictor: gshare direction predictor plus a tagged, valid-qualified branch target buffer (BTB).
- The direction table (BHT) is indexed by PC XOR global history register (GHR). The BTB is indexed by PC and checked against a tag.
- Sits beside the IF stage: lookup is combinational on pc_fetch; updates arrive from the branch-resolution stage.

Parameters:
- N, 128, entries in the BHT and in the BTB; N = 2^IDX.
- IDX, 7, index width.
- CTR_W, 2, saturating counter width; legal 2..4.
- HIST_W, 4, GHR length; legal 1..IDX.
- TAG_W, 4, BTB tag width; IDX+TAG_W <= 15.

Ports:
- clk  in  1  clock; all state updates on its rising edge.
- rst_n  in  1  reset; synchronous, active-low.
- pc_fetch  in  16  lookup PC.
- predict_taken  out  1  predicted taken.
- predict_target  out  16  predicted target.
- btb_hit  out  1  BTB entry valid and tag match for pc_fetch.
- ghr  out  HIST_W  current global history.
- update_en  in  1  branch resolved this cycle.
- pc_resolve  in  16  PC of the resolved branch.
- taken  in  1  resolved direction.
- target  in  16  resolved target.
- update_mispredict  in  1  resolved branch was mispredicted; qualifies stats only.
- ghr_restore_en  in  1  overwrite GHR (flush recovery).
- ghr_restore_val  in  HIST_W  value loaded into the GHR.

Behaviour:
- Index math:
  - bidx(pc) = pc[IDX:1] XOR zero-extended GHR (GHR occupies the low HIST_W bits).
  - tidx(pc) = pc[IDX:1].
  - tag(pc) = pc[IDX+TAG_W:IDX+1].
- Lookup (combinational, 0 cycles):
  - btb_hit = valid[tidx] AND tag match.
  - predict_taken = BHT[bidx] MSB AND btb_hit.
  - predict_target = BTB target when predict_taken, else 16'h0000.
- Update (takes effect at the rising edge where update_en=1):
  - BHT[bidx(pc_resolve)], computed with the pre-edge GHR, increments when taken and decrements otherwise.
  - The counter saturates at 0 and at 2^CTR_W-1.
  - When taken: BTB[tidx] <= {valid=1, tag(pc_resolve), target}. When not taken, the BTB is untouched.
- GHR:
  - On update_en: GHR <= {GHR[HIST_W-2:0], taken}. When HIST_W=1, GHR <= taken.
  - When ghr_restore_en=1, GHR <= ghr_restore_val. Restore wins over the update_en shift in the same cycle; the table writes for that update still use the pre-edge GHR.
- Reset (rst_n=0 at a rising edge, including mid-operation):
  - Every BHT counter <= weakly-not-taken, 2^(CTR_W-1)-1 (01 for CTR_W=2).
  - All BTB valid bits, tags and targets <= 0.
  - GHR <= 0; stats <= 0.
  - Resulting outputs: predict_taken=0, predict_target=0, btb_hit=0, ghr=0.
  - Reset overrides update_en and ghr_restore_en in the same cycle.
- Same-cycle lookup and update hitting the same entry: lookup returns the pre-edge contents. There is no bypass; the new value is visible the next cycle.
- Updates with update_en=0 are ignored; the pc_resolve/taken/target values don't matter.

Optional Feature:
- Macro: GSHARE_PREDICTOR_STATS_EN.
- When defined, adds outputs stat_updates[31:0] and stat_mispredicts[31:0]:
  - stat_updates increments on every update_en.
  - stat_mispredicts increments on update_en AND update_mispredict.
  - Both saturate at 32'hFFFF_FFFF and clear on reset.
- When undefined, these ports and registers do not exist, and update_mispredict is ignored.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles, then sweep pc_fetch over 0x0000..0x00FE -> predict_taken=0, btb_hit=0, predict_target=0, ghr=0 on every value.
- Saturation:
  - Apply 3 updates of pc 0x0010, taken, target 0x0040, each with ghr_restore_en=1 and ghr_restore_val=0 -> lookup 0x0010 gives predict_taken=1, target 0x0040.
  - Then 3 not-taken updates (with the same restore) -> counter 00, predict_taken=0, btb_hit=1.
  - Then 1 taken update -> counter 01, predict_taken=0.
- Tag miss: after training 0x0010, look up 0x0110 (same tidx 0x08, tag 1 vs 0) -> btb_hit=0, predict_taken=0, predict_target=0.
- Gshare: from reset, apply 1 taken update of 0x0010 (bidx 0x08, counter 10) -> ghr=0001. Lookup 0x0010 then uses bidx 0x09 (counter 01) -> btb_hit=1, predict_taken=0.
- Same-cycle collision: with lookup and update on 0x0010 in one cycle, lookup shows the pre-update counter; the next cycle shows the updated counter. When ghr_restore_en is asserted with update_en, ghr equals ghr_restore_val.
- Mid-run reset with STATS_EN: after 5 updates (2 mispredicts), stat_updates=5 and stat_mispredicts=2. Pulse rst_n=0 for 1 cycle -> all tables, ghr and stats are 0, and a previously trained PC predicts not taken.
